// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions.
// Stall codes are read by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// The package also holds the stall/flush FSM state encoding and a bundle type
// for the four per-register stall codes.
package pipe_ctrl_pkg;

  // Stall code driven to each pipeline register. 2'b11 is never produced.
  localparam logic [1:0] STALL_NEXT = 2'b00;  // load from upstream stage
  localparam logic [1:0] STALL_KEEP = 2'b01;  // hold current contents
  localparam logic [1:0] STALL_ZERO = 2'b10;  // insert a bubble

  // StDrain: a taken redirect is waiting for a stale fetch to return.
  typedef enum logic {
    StIdle  = 1'b0,
    StDrain = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic [1:0] if_id;
    logic [1:0] id_ex;
    logic [1:0] ex_mem;
    logic [1:0] mem_wb;
  } stall_codes_t;

  function automatic stall_codes_t make_codes(input logic [1:0] if_id,
                                              input logic [1:0] id_ex,
                                              input logic [1:0] ex_mem,
                                              input logic [1:0] mem_wb);
    stall_codes_t c;
    c.if_id  = if_id;
    c.id_ex  = id_ex;
    c.ex_mem = ex_mem;
    c.mem_wb = mem_wb;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   inc   - increment request for this cycle
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline stall/flush controller.
// Arbitrates, in fixed priority order: memory wait, multi-cycle execute,
// control-flow redirect from EX, and load-use hazards. A two-state FSM holds
// back a redirect until an outstanding (now stale) fetch has returned, so
// that the returning instruction can be discarded.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   if_busy             - fetch outstanding, no valid instruction in IF
//   id_load_use         - ID depends on a load in EX
//   ex_busy             - multi-cycle op in EX not finished
//   ex_redirect_valid   - taken branch/jump/trap resolved in EX
//   ex_redirect_pc      - redirect target from EX
//   mem_busy            - bus transaction in MEM not finished
//   pc_stall            - PC holds its value
//   redirect_valid      - PC loads redirect_pc (overrides pc_stall)
//   redirect_pc         - PC target, zero when redirect_valid is low
//   *_stall             - stall code per pipeline register
//   stall_cnt           - saturating count of cycles with pc_stall high
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_busy,
  input  logic              id_load_use,
  input  logic              ex_busy,
  input  logic              ex_redirect_valid,
  input  logic [ADDR_W-1:0] ex_redirect_pc,
  input  logic              mem_busy,
  output logic              pc_stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        if_id_stall,
  output logic [1:0]        id_ex_stall,
  output logic [1:0]        ex_mem_stall,
  output logic [1:0]        mem_wb_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  stall_codes_t      codes;

  always_comb begin
    state_d        = state_q;
    pend_pc_d      = pend_pc_q;
    pc_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    codes          = make_codes(STALL_NEXT, STALL_NEXT, STALL_NEXT, STALL_NEXT);

    if (rst) begin
      pc_stall = 1'b1;
      codes    = make_codes(STALL_ZERO, STALL_ZERO, STALL_ZERO, STALL_ZERO);
    end else if (mem_busy) begin
      // Freeze everything upstream of MEM; WB sees a bubble.
      pc_stall = 1'b1;
      codes    = make_codes(STALL_KEEP, STALL_KEEP, STALL_KEEP, STALL_ZERO);
    end else if (ex_busy) begin
      pc_stall = 1'b1;
      codes    = make_codes(STALL_KEEP, STALL_KEEP, STALL_ZERO, STALL_NEXT);
    end else if (state_q == StIdle && ex_redirect_valid && !if_busy) begin
      redirect_valid = 1'b1;
      redirect_pc    = ex_redirect_pc;
      codes          = make_codes(STALL_ZERO, STALL_ZERO, STALL_NEXT, STALL_NEXT);
    end else if (state_q == StIdle && ex_redirect_valid && if_busy) begin
      // Fetch in flight is now stale: remember the target, wait it out.
      pc_stall  = 1'b1;
      pend_pc_d = ex_redirect_pc;
      state_d   = StDrain;
      codes     = make_codes(STALL_ZERO, STALL_ZERO, STALL_NEXT, STALL_NEXT);
    end else if (state_q == StDrain && if_busy) begin
      pc_stall = 1'b1;
      codes    = make_codes(STALL_ZERO, STALL_ZERO, STALL_NEXT, STALL_NEXT);
    end else if (state_q == StDrain) begin
      // Stale instruction arrives now and is bubbled; PC takes the saved target.
      redirect_valid = 1'b1;
      redirect_pc    = pend_pc_q;
      state_d        = StIdle;
      codes          = make_codes(STALL_ZERO, STALL_ZERO, STALL_NEXT, STALL_NEXT);
    end else if (id_load_use) begin
      pc_stall = 1'b1;
      codes    = make_codes(STALL_KEEP, STALL_ZERO, STALL_NEXT, STALL_NEXT);
    end else if (if_busy) begin
      pc_stall = 1'b1;
      codes    = make_codes(STALL_ZERO, STALL_NEXT, STALL_NEXT, STALL_NEXT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign if_id_stall  = codes.if_id;
  assign id_ex_stall  = codes.id_ex;
  assign ex_mem_stall = codes.ex_mem;
  assign mem_wb_stall = codes.mem_wb;

  // pc_stall is forced high during reset; those cycles are not counted.
  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (pc_stall & ~rst),
    .count(stall_cnt)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline stall/flush controller. It drives the 2-bit stall code consumed by every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC hold and PC redirect.
- Arbitrates memory wait, multi-cycle execute, control-flow redirect and load-use hazards.
- Owns a small FSM that discards an in-flight fetch made stale by a taken branch.
- Sits beside the datapath and is driven by the IF, ID, EX and MEM stage status signals.

Parameters:
- ADDR_W, 64, PC / redirect address width (matches REG_BUS).
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
- if_busy  in  1  instruction fetch outstanding; IF has no valid instruction this cycle.
- id_load_use  in  1  instruction in ID depends on a load currently in EX.
- ex_busy  in  1  multi-cycle op (mul/div) in EX not finished.
- ex_redirect_valid  in  1  taken branch/jump/trap resolved in EX. Held high while that instruction sits in EX.
- ex_redirect_pc  in  ADDR_W  redirect target.
- mem_busy  in  1  load/store bus transaction in MEM not finished.
- pc_stall  out  1  1 = PC register holds its value.
- redirect_valid  out  1  1 = PC loads redirect_pc at this edge (overrides pc_stall).
- redirect_pc  out  ADDR_W  target for PC.
- if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  2 each  STALL_NEXT / STALL_KEEP / STALL_ZERO.
- stall_cnt  out  CNT_W  count of cycles with pc_stall=1.

Behaviour:
- Stall codes: STALL_NEXT=2'b00 (load upstream), STALL_KEEP=2'b01 (hold), STALL_ZERO=2'b10 (insert bubble). Code 2'b11 is never driven.
- Stall/redirect outputs are combinational from registered FSM state and current inputs, so they are sampled by the pipeline registers at the same edge. Zero latency.
- FSM states: IDLE, DRAIN. Registers: state, pend_pc.
- Reset (clocked): state=IDLE, pend_pc=0, stall_cnt=0. While rst=1, outputs are forced to pc_stall=1, redirect_valid=0, redirect_pc=0, all stall codes STALL_ZERO.
- Priority per cycle, first match wins:
  1. mem_busy: pc_stall=1; IF/ID, ID/EX, EX/MEM = KEEP; MEM/WB = ZERO. FSM state unchanged.
  2. ex_busy: pc_stall=1; IF/ID, ID/EX = KEEP; EX/MEM = ZERO; MEM/WB = NEXT.
  3. IDLE & ex_redirect_valid & !if_busy: redirect_valid=1, redirect_pc=ex_redirect_pc; IF/ID, ID/EX = ZERO; EX/MEM, MEM/WB = NEXT.
  4. IDLE & ex_redirect_valid & if_busy: pc_stall=1; pend_pc<=ex_redirect_pc; state<=DRAIN; IF/ID, ID/EX = ZERO; EX/MEM, MEM/WB = NEXT.
  5. DRAIN & if_busy: pc_stall=1; IF/ID, ID/EX = ZERO; rest NEXT.
  6. DRAIN & !if_busy: the returning stale instruction is discarded (IF/ID = ZERO, ID/EX = ZERO). redirect_valid=1, redirect_pc=pend_pc; state<=IDLE.
  7. id_load_use: pc_stall=1; IF/ID = KEEP; ID/EX = ZERO; rest NEXT.
  8. if_busy: pc_stall=1; IF/ID = ZERO; rest NEXT.
  9. Otherwise: all NEXT, pc_stall=0.
- redirect_valid=0 in every case except 3 and 6. redirect_pc=0 when redirect_valid=0.
- Simultaneous events:
  - Redirect plus load-use: redirect wins; the load-use instruction is squashed.
  - Redirect plus mem_busy/ex_busy: no redirect this cycle. EX holds the branch, so ex_redirect_valid is re-presented next cycle.
  - ex_redirect_valid while in DRAIN: ignored. ID/EX is bubbled, so this is illegal and is flagged by a bench assertion.
- stall_cnt: increments by 1 on every non-reset cycle with pc_stall=1. It saturates at all-ones and does not wrap.
- Reset asserted in DRAIN: returns to IDLE and drops pend_pc. No redirect is issued.

Decomposition:
- STALL_NEXT/KEEP/ZERO and the FSM state encodings (IDLE=1'b0, DRAIN=1'b1) live in the shared defines header, used by all pipeline registers.
- The priority mux and FSM stay in one module.
- The saturating counter is a natural small sub-module: sat_counter (params WIDTH; ports clk, rst, inc, count).

Test Plan:
- Reset: hold rst 2 cycles -> all stall codes 2'b10, pc_stall=1, stall_cnt=0. First cycle after reset with idle inputs -> all 2'b00, pc_stall=0.
- Load-use: id_load_use=1 for 1 cycle -> if_id=01, id_ex=10, ex_mem=00, mem_wb=00, pc_stall=1, stall_cnt=1.
- Redirect, fetch idle: ex_redirect_valid=1, pc=0x8000_0100 -> redirect_valid=1, redirect_pc=0x8000_0100, if_id=10, id_ex=10, pc_stall=0.
- Redirect during fetch: ex_redirect_valid=1, if_busy=1 for 3 cycles, then 0 -> DRAIN for 3 cycles with if_id=10. On if_busy fall: redirect_valid=1 to pend_pc, state IDLE. stall_cnt +3.
- Memory wait beats redirect: mem_busy=1 and ex_redirect_valid=1 for 4 cycles -> if_id/id_ex/ex_mem=01, mem_wb=10, no redirect. Cycle 5 with mem_busy=0 -> redirect issued.
- Counter saturation / mid-DRAIN reset: CNT_W=4, 20 stall cycles -> stall_cnt=15. Reset while DRAIN -> IDLE, redirect_valid never asserted.
